// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: round-robin AXI-Stream packet arbiter with a registered output slice.
// A grant holds for a whole packet; a beat limit forces last so no source can monopolise the channel.
module axis_pkt_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ*WIDTH-1:0] s_axis_data,
  input  logic [NREQ-1:0]       s_axis_valid,
  input  logic [NREQ-1:0]       s_axis_last,
  output logic [NREQ-1:0]       s_axis_ready,
  output logic [WIDTH-1:0]      m_axis_data,
  output logic                  m_axis_valid,
  output logic                  m_axis_last,
  input  logic                  m_axis_ready,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  trunc
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BEATS + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]     gidx_q, gidx_d, lastg_q, lastg_d, win;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              valid_q, valid_d, last_q, last_d, trunc_q, trunc_d;
  logic              out_free, acc, force_last;
  assign out_free     = !valid_q || m_axis_ready;
  assign s_axis_ready = grant_q & {NREQ{out_free}};
  assign acc          = (state_q == BUSY) && s_axis_valid[gidx_q] && out_free;
  assign force_last   = cnt_q == CW'(MAX_BEATS - 1);
  assign grant        = grant_q;
  assign busy         = state_q == BUSY;
  assign m_axis_data  = data_q;
  assign m_axis_valid = valid_q;
  assign m_axis_last  = last_q;
  assign trunc        = trunc_q;
  // Scan downward so the nearest requester after lastg_q is written last and wins.
  always_comb begin
    win = lastg_q;
    for (int k = NREQ; k >= 1; k--)
      if (s_axis_valid[IW'((int'(lastg_q) + k) % NREQ)]) win = IW'((int'(lastg_q) + k) % NREQ);
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    lastg_d = lastg_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q && !m_axis_ready;
    last_d  = last_q;
    trunc_d = 1'b0;
    if (state_q == IDLE) begin
      if (|s_axis_valid) begin
        state_d = BUSY;
        gidx_d  = win;
        grant_d = NREQ'(1) << win;
        cnt_d   = '0;
      end
    end else if (acc) begin
      data_d  = s_axis_data[int'(gidx_q)*WIDTH +: WIDTH];
      valid_d = 1'b1;
      last_d  = s_axis_last[gidx_q] || force_last;
      trunc_d = force_last && !s_axis_last[gidx_q];
      cnt_d   = cnt_q + CW'(1);
      if (last_d) begin
        state_d = IDLE;
        grant_d = '0;
        lastg_d = gidx_q;
        cnt_d   = '0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      lastg_q <= IW'(NREQ - 1);
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      lastg_q <= lastg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      trunc_q <= trunc_d;
    end
  end
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: randomized scenarios checked against a per-cycle behavioural model of the arbiter.
module tb_axis_pkt_arbiter;
  localparam int N = 4, W = 8, MB = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [N*W-1:0] s_data;
  logic [N-1:0] s_valid, s_last, s_ready, grant;
  logic [W-1:0] m_data;
  logic m_valid, m_last, m_ready, busy, trunc;
  axis_pkt_arbiter #(.WIDTH(W), .NREQ(N), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst), .s_axis_data(s_data), .s_axis_valid(s_valid), .s_axis_last(s_last),
    .s_axis_ready(s_ready), .m_axis_data(m_data), .m_axis_valid(m_valid), .m_axis_last(m_last),
    .m_axis_ready(m_ready), .grant(grant), .busy(busy), .trunc(trunc));
  always #5 clk = ~clk;
  logic [8:0] sq [N][$];
  logic [8:0] olog [$];
  logic [3:0] glog [$];
  logic [3:0] en, pv, pl, pgrant, e_grant, e_rdy;
  logic [N*W-1:0] pd;
  logic pmr, e_busy, mov, mol, mtr, primed;
  logic [7:0] mod;
  int mo, mlg, mcnt, vpct, rpct, trunc_seen, vectors, fails;

  function automatic int pick(int lg, logic [3:0] v);
    for (int k = 1; k <= N; k++) if (v[(lg + k) % N]) return (lg + k) % N;
    return -1;
  endfunction
  function automatic bit drained();
    return sq[0].size() == 0 && sq[1].size() == 0 && sq[2].size() == 0 && sq[3].size() == 0 && mo < 0 && !mov;
  endfunction
  task automatic push_pkt(int s, int len, int base);
    for (int b = 0; b < len; b++) sq[s].push_back({1'(b == len - 1), base < 0 ? 8'($urandom) : 8'(base + b)});
  endtask
  task automatic model_reset();
    mo = -1; mlg = N - 1; mcnt = 0; mov = 0; mol = 0; mod = 0; mtr = 0; primed = 0;
    for (int i = 0; i < N; i++) sq[i].delete();
    olog.delete(); glog.delete(); pgrant = 0; trunc_seen = 0;
    en = 0; vpct = 100; rpct = 100;
    s_valid = 0; s_last = 0; s_data = 0; m_ready = 0;
  endtask
  task automatic apply_reset();
    @(negedge clk); rst = 1'b1; model_reset();
    @(negedge clk); rst = 1'b0;
  endtask
  // Advance the model across the last clock edge, drive new inputs, and set expectations for this cycle.
  task automatic step();
    logic acc;
    @(negedge clk);
    if (primed) begin
      acc = mo >= 0 && pv[mo] && (!mov || pmr);
      mtr = 0;
      if (mo < 0) begin
        if (pv != 0) begin mo = pick(mlg, pv); mcnt = 0; end
        if (pmr) mov = 0;
      end else if (acc) begin
        mod = pd[mo*W +: W];
        mol = pl[mo] || mcnt == MB - 1;
        mtr = mol && !pl[mo];
        mov = 1;
        void'(sq[mo].pop_front());
        mcnt++;
        if (mol) begin mlg = mo; mo = -1; end
      end else if (pmr) mov = 0;
    end
    for (int i = 0; i < N; i++) begin
      pv[i] = en[i] && sq[i].size() > 0 && $urandom_range(99) < vpct;
      pl[i] = sq[i].size() > 0 ? sq[i][0][8] : 1'b0;
      pd[i*W +: W] = sq[i].size() > 0 ? sq[i][0][7:0] : 8'($urandom);
    end
    pmr = $urandom_range(99) < rpct;
    s_valid = pv; s_last = pl; s_data = pd; m_ready = pmr; primed = 1;
    #1;
    e_grant = mo < 0 ? 4'b0 : 4'b1 << mo;
    e_busy = mo >= 0;
    e_rdy = e_grant & {4{!mov || pmr}};
    if (m_valid && m_ready) olog.push_back({m_last, m_data});
    if (grant !== 0 && pgrant === 0) glog.push_back(grant);
    pgrant = grant;
    if (trunc === 1'b1) trunc_seen++;
  endtask

  task automatic test_reset();
    model_reset();
    s_valid = 4'hf; m_ready = 1;
    @(posedge clk); #1;
    vectors++;
    if ({grant, busy, s_ready} !== 9'b0) begin
      fails++; $display("FAIL reset_ctrl got %h exp 0", {grant, busy, s_ready});
    end
    vectors++;
    if ({m_valid, m_last, m_data, trunc} !== 11'b0) begin
      fails++; $display("FAIL reset_out got %h exp 0", {m_valid, m_last, m_data, trunc});
    end
    s_valid = 0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    push_pkt(1, 3, 8'h41); en = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      step();
      vectors++;
      if ({grant, busy, s_ready, m_valid, trunc} !== {e_grant, e_busy, e_rdy, mov, mtr}) begin
        fails++; $display("FAIL single_ctrl got %h exp %h", {grant, busy, s_ready, m_valid, trunc}, {e_grant, e_busy, e_rdy, mov, mtr});
      end
      if (mov) begin
        vectors++;
        if ({m_last, m_data} !== {mol, mod}) begin fails++; $display("FAIL single_beat got %h exp %h", {m_last, m_data}, {mol, mod}); end
      end
    end
    vectors++;
    if (glog.size() != 1 || glog[0] !== 4'b0010) begin fails++; $display("FAIL single_grant got %p exp 2", glog); end
    vectors++;
    if (olog.size() != 3) begin fails++; $display("FAIL single_count got %0d exp 3", olog.size()); end
    else for (int i = 0; i < 3; i++) begin
      vectors++;
      if (olog[i] !== {1'(i == 2), 8'(8'h41 + i)}) begin fails++; $display("FAIL single_byte%0d got %h exp %h", i, olog[i], {1'(i == 2), 8'(8'h41 + i)}); end
    end
    vectors++;
    if ({grant, busy} !== 5'b0) begin fails++; $display("FAIL single_idle got %h exp 0", {grant, busy}); end
  endtask

  task automatic test_round_robin();
    int c = 0;
    apply_reset();
    for (int p = 0; p < 4; p++) begin push_pkt(0, 2, -1); push_pkt(2, 2, -1); end
    en = 4'b0101;
    while (!drained() && c < 200) begin
      step(); c++;
      vectors++;
      if ({grant, busy, s_ready, m_valid, trunc} !== {e_grant, e_busy, e_rdy, mov, mtr}) begin
        fails++; $display("FAIL rr_ctrl got %h exp %h", {grant, busy, s_ready, m_valid, trunc}, {e_grant, e_busy, e_rdy, mov, mtr});
      end
      if (mov) begin
        vectors++;
        if ({m_last, m_data} !== {mol, mod}) begin fails++; $display("FAIL rr_beat got %h exp %h", {m_last, m_data}, {mol, mod}); end
      end
    end
    vectors++;
    if (!drained()) begin fails++; $display("FAIL rr_timeout got busy exp drained"); end
    vectors++;
    if (glog.size() != 8) begin fails++; $display("FAIL rr_count got %0d exp 8", glog.size()); end
    else for (int i = 0; i < 8; i++) begin
      vectors++;
      if (glog[i] !== (i % 2 == 0 ? 4'b0001 : 4'b0100)) begin fails++; $display("FAIL rr_order%0d got %b exp %b", i, glog[i], i % 2 == 0 ? 4'b0001 : 4'b0100); end
    end
  endtask

  task automatic test_backpressure();
    int c = 0;
    apply_reset();
    push_pkt(1, 6, 8'h10); en = 4'b0010;
    while (!drained() && c < 100) begin
      rpct = (c >= 4 && c < 9) ? 0 : 100;
      step(); c++;
      vectors++;
      if ({grant, busy, s_ready, m_valid, trunc} !== {e_grant, e_busy, e_rdy, mov, mtr}) begin
        fails++; $display("FAIL bp_ctrl got %h exp %h", {grant, busy, s_ready, m_valid, trunc}, {e_grant, e_busy, e_rdy, mov, mtr});
      end
      if (mov) begin
        vectors++;
        if ({m_last, m_data} !== {mol, mod}) begin fails++; $display("FAIL bp_beat got %h exp %h", {m_last, m_data}, {mol, mod}); end
      end
    end
    vectors++;
    if (olog.size() != 6) begin fails++; $display("FAIL bp_count got %0d exp 6", olog.size()); end
    else for (int i = 0; i < 6; i++) begin
      vectors++;
      if (olog[i] !== {1'(i == 5), 8'(8'h10 + i)}) begin fails++; $display("FAIL bp_byte%0d got %h exp %h", i, olog[i], {1'(i == 5), 8'(8'h10 + i)}); end
    end
  endtask

  task automatic test_truncation();
    int c = 0;
    apply_reset();
    push_pkt(3, 20, 8'h80); en = 4'b1000;
    while (!drained() && c < 200) begin
      step(); c++;
      vectors++;
      if ({grant, busy, s_ready, m_valid, trunc} !== {e_grant, e_busy, e_rdy, mov, mtr}) begin
        fails++; $display("FAIL trunc_ctrl got %h exp %h", {grant, busy, s_ready, m_valid, trunc}, {e_grant, e_busy, e_rdy, mov, mtr});
      end
      if (mov) begin
        vectors++;
        if ({m_last, m_data} !== {mol, mod}) begin fails++; $display("FAIL trunc_beat got %h exp %h", {m_last, m_data}, {mol, mod}); end
      end
    end
    vectors++;
    if (olog.size() != 20) begin fails++; $display("FAIL trunc_count got %0d exp 20", olog.size()); end
    else begin
      vectors++;
      if (olog[15] !== 9'h18f || olog[19] !== 9'h193 || olog[14][8] !== 1'b0) begin
        fails++; $display("FAIL trunc_last got %h %h %h exp 08e 18f 193", olog[14], olog[15], olog[19]);
      end
    end
    vectors++;
    if (trunc_seen != 1) begin fails++; $display("FAIL trunc_pulse got %0d exp 1", trunc_seen); end
    vectors++;
    if (glog.size() != 2 || glog[0] !== 4'b1000 || glog[1] !== 4'b1000) begin fails++; $display("FAIL trunc_regrant got %p exp 8 8", glog); end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    apply_reset();
    push_pkt(0, 5, 8'h30); en = 4'b0001;
    while (mcnt != 2 && c < 20) begin step(); c++; end
    vectors++;
    if (busy !== 1'b1 || m_valid !== 1'b1) begin fails++; $display("FAIL rmid_pre got %b%b exp 11", busy, m_valid); end
    rst = 1'b1; #1;
    vectors++;
    if ({grant, busy, s_ready, m_valid, m_last, m_data, trunc} !== 20'b0) begin
      fails++; $display("FAIL rmid_async got %h exp 0", {grant, busy, s_ready, m_valid, m_last, m_data, trunc});
    end
    model_reset();
    #2 rst = 1'b0;
    push_pkt(0, 1, 8'h50); push_pkt(1, 1, 8'h60); en = 4'b0011;
    c = 0;
    while (!drained() && c < 50) begin
      step(); c++;
      vectors++;
      if ({grant, busy, s_ready, m_valid, trunc} !== {e_grant, e_busy, e_rdy, mov, mtr}) begin
        fails++; $display("FAIL rmid_ctrl got %h exp %h", {grant, busy, s_ready, m_valid, trunc}, {e_grant, e_busy, e_rdy, mov, mtr});
      end
    end
    vectors++;
    if (glog.size() != 2 || glog[0] !== 4'b0001 || glog[1] !== 4'b0010) begin fails++; $display("FAIL rmid_order got %p exp 1 2", glog); end
  endtask

  task automatic test_stall();
    int c = 0;
    apply_reset();
    push_pkt(2, 6, 8'h20); push_pkt(0, 2, 8'h70); en = 4'b0100;
    while (mcnt != 2 && c < 20) begin step(); c++; end
    en = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if ({grant, busy, s_ready[0]} !== 6'b0100_1_0) begin fails++; $display("FAIL stall_hold got %h exp 12", {grant, busy, s_ready[0]}); end
    end
    en = 4'b0101; c = 0;
    while (!drained() && c < 100) begin
      step(); c++;
      vectors++;
      if ({grant, busy, s_ready, m_valid, trunc} !== {e_grant, e_busy, e_rdy, mov, mtr}) begin
        fails++; $display("FAIL stall_ctrl got %h exp %h", {grant, busy, s_ready, m_valid, trunc}, {e_grant, e_busy, e_rdy, mov, mtr});
      end
      if (mov) begin
        vectors++;
        if ({m_last, m_data} !== {mol, mod}) begin fails++; $display("FAIL stall_beat got %h exp %h", {m_last, m_data}, {mol, mod}); end
      end
    end
    vectors++;
    if (glog.size() != 2 || glog[0] !== 4'b0100 || glog[1] !== 4'b0001) begin fails++; $display("FAIL stall_order got %p exp 4 1", glog); end
  endtask

  task automatic test_random();
    int c = 0;
    apply_reset();
    for (int s = 0; s < N; s++)
      for (int p = $urandom_range(4, 1); p > 0; p--) push_pkt(s, $urandom_range(20, 1), -1);
    en = 4'hf; vpct = 70; rpct = 70;
    while (!drained() && c < 3000) begin
      step(); c++;
      vectors++;
      if ({grant, busy, s_ready, m_valid, trunc} !== {e_grant, e_busy, e_rdy, mov, mtr}) begin
        fails++; $display("FAIL rand_ctrl got %h exp %h", {grant, busy, s_ready, m_valid, trunc}, {e_grant, e_busy, e_rdy, mov, mtr});
      end
      if (mov) begin
        vectors++;
        if ({m_last, m_data} !== {mol, mod}) begin fails++; $display("FAIL rand_beat got %h exp %h", {m_last, m_data}, {mol, mod}); end
      end
    end
    vectors++;
    if (!drained()) begin fails++; $display("FAIL rand_timeout got busy exp drained"); end
  endtask

  initial begin
    vectors = 0; fails = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_truncation();
    test_reset_mid();
    test_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
